// File: rtl/div_arbiter_if.sv
// Bundle of requester, result and divider handshakes around the shared divider arbiter.
// slave is the arbiter's view; master is the surrounding issue logic and divider.
interface div_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_STB;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_BUSY;
    logic [31:0]           rsp_div;
    logic [NUM_REQ-1:0]    rsp_STB;
    logic [NUM_REQ-1:0]    rsp_module_BUSY;
    logic [31:0]           div_input_a;
    logic [31:0]           div_input_b;
    logic                  div_input_STB;
    logic                  div_BUSY;
    logic [31:0]           div_output;
    logic                  div_output_STB;
    logic                  output_module_BUSY;
    logic [IDX_W-1:0]      grant_idx;
    logic                  arb_active;

    modport slave (
        input  req_STB, req_a, req_b, rsp_module_BUSY,
        input  div_BUSY, div_output, div_output_STB,
        output req_BUSY, rsp_div, rsp_STB,
        output div_input_a, div_input_b, div_input_STB, output_module_BUSY,
        output grant_idx, arb_active
    );

    modport master (
        output req_STB, req_a, req_b, rsp_module_BUSY,
        output div_BUSY, div_output, div_output_STB,
        input  req_BUSY, rsp_div, rsp_STB,
        input  div_input_a, div_input_b, div_input_STB, output_module_BUSY,
        input  grant_idx, arb_active
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one FPU divider among NUM_REQ requesters, one operation in flight.
// Every output is a register; the FSM walks IDLE -> GRANT -> ISSUE -> WAIT -> RETURN.
module div_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    div_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        RETURN = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] req_busy_reg, req_busy_next;
    logic [NUM_REQ-1:0] rsp_stb_reg, rsp_stb_next;
    logic [31:0]        rsp_div_reg, rsp_div_next;
    logic [31:0]        div_a_reg, div_a_next;
    logic [31:0]        div_b_reg, div_b_next;
    logic               div_stb_reg, div_stb_next;
    logic               out_busy_reg, out_busy_next;
    logic [IDX_W-1:0]   grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic               arb_active_reg, arb_active_next;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [IDX_W-1:0]   sel_plus1;
    logic               sel_stb;
    logic               div_in_xfer;
    logic               div_out_xfer;
    logic               rsp_xfer;

    // Scan offset gi maps to requester (rr_ptr + gi) mod NUM_REQ.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                                  IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
            assign cand_hit[gi] = bus.req_STB[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_idx = cand_idx[k];
                win_any = 1'b1;
            end
        end
    end

    assign sel_plus1    = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_reg + IDX_W'(1);
    assign sel_stb      = bus.req_STB[grant_idx_reg];
    assign div_in_xfer  = div_stb_reg && !bus.div_BUSY;
    assign div_out_xfer = bus.div_output_STB && !out_busy_reg;
    assign rsp_xfer     = rsp_stb_reg[grant_idx_reg] && !bus.rsp_module_BUSY[grant_idx_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_busy_reg   <= '1;
            rsp_stb_reg    <= '0;
            rsp_div_reg    <= '0;
            div_a_reg      <= '0;
            div_b_reg      <= '0;
            div_stb_reg    <= 1'b0;
            out_busy_reg   <= 1'b1;
            grant_idx_reg  <= '0;
            rr_ptr_reg     <= '0;
            arb_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_busy_reg   <= req_busy_next;
            rsp_stb_reg    <= rsp_stb_next;
            rsp_div_reg    <= rsp_div_next;
            div_a_reg      <= div_a_next;
            div_b_reg      <= div_b_next;
            div_stb_reg    <= div_stb_next;
            out_busy_reg   <= out_busy_next;
            grant_idx_reg  <= grant_idx_next;
            rr_ptr_reg     <= rr_ptr_next;
            arb_active_reg <= arb_active_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_any) state_next = GRANT;
            GRANT:   state_next = sel_stb ? ISSUE : IDLE;
            ISSUE:   if (div_in_xfer) state_next = WAIT;
            WAIT:    if (div_out_xfer) state_next = RETURN;
            RETURN:  if (rsp_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_busy_next   = req_busy_reg;
        rsp_stb_next    = rsp_stb_reg;
        rsp_div_next    = rsp_div_reg;
        div_a_next      = div_a_reg;
        div_b_next      = div_b_reg;
        div_stb_next    = div_stb_reg;
        out_busy_next   = out_busy_reg;
        grant_idx_next  = grant_idx_reg;
        rr_ptr_next     = rr_ptr_reg;
        arb_active_next = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    grant_idx_next = win_idx;
                    req_busy_next  = ~(NUM_REQ'(1) << win_idx);
                end
            end
            GRANT: begin
                // A withdrawn request simply closes the window; rr_ptr stays put.
                req_busy_next = '1;
                if (sel_stb) begin
                    div_a_next   = bus.req_a[32*grant_idx_reg +: 32];
                    div_b_next   = bus.req_b[32*grant_idx_reg +: 32];
                    div_stb_next = 1'b1;
                end
            end
            ISSUE: begin
                if (div_in_xfer) begin
                    div_stb_next  = 1'b0;
                    out_busy_next = 1'b0;
                end
            end
            WAIT: begin
                if (div_out_xfer) begin
                    rsp_div_next  = bus.div_output;
                    out_busy_next = 1'b1;
                    rsp_stb_next  = NUM_REQ'(1) << grant_idx_reg;
                end
            end
            RETURN: begin
                if (rsp_xfer) begin
                    rsp_stb_next = '0;
                    rr_ptr_next  = sel_plus1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_BUSY           = req_busy_reg;
    assign bus.rsp_STB            = rsp_stb_reg;
    assign bus.rsp_div            = rsp_div_reg;
    assign bus.div_input_a        = div_a_reg;
    assign bus.div_input_b        = div_b_reg;
    assign bus.div_input_STB      = div_stb_reg;
    assign bus.output_module_BUSY = out_busy_reg;
    assign bus.grant_idx          = grant_idx_reg;
    assign bus.arb_active         = arb_active_reg;
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized traffic
// scored against a queue-based model of round-robin service and result routing.
module tb_div_arbiter;
    localparam int N       = 4;
    localparam int NUM_OPS = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.NUM_REQ(N)) bus ();
    div_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_pass  = 0;
    int n_total = 0;

    // Divider stub: exact quotients for the directed operands, a fixed mixing function otherwise.
    function automatic logic [31:0] mock_quotient(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h3F000000;
        if (a == 32'h3F800000 && b == 32'h00000000) return 32'h7F800000;
        return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
    endfunction

    logic        dv_rand = 1'b0;
    int          dv_lat  = 2;
    int          dv_state;
    int          dv_cnt;
    logic [31:0] dv_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_state           <= 0;
            dv_cnt             <= 0;
            dv_res             <= '0;
            bus.div_BUSY       <= 1'b0;
            bus.div_output     <= '0;
            bus.div_output_STB <= 1'b0;
        end else begin
            case (dv_state)
                0: begin
                    if (bus.div_input_STB && !bus.div_BUSY) begin
                        dv_res       <= mock_quotient(bus.div_input_a, bus.div_input_b);
                        dv_cnt       <= dv_rand ? int'($urandom_range(0, 6)) : dv_lat;
                        dv_state     <= 1;
                        bus.div_BUSY <= 1'b1;
                    end else begin
                        bus.div_BUSY <= dv_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
                    end
                end
                1: begin
                    if (dv_cnt == 0) begin
                        bus.div_output     <= dv_res;
                        bus.div_output_STB <= 1'b1;
                        dv_state           <= 2;
                    end else begin
                        dv_cnt <= dv_cnt - 1;
                    end
                end
                default: begin
                    if (!bus.output_module_BUSY) begin
                        bus.div_output_STB <= 1'b0;
                        bus.div_BUSY       <= 1'b0;
                        dv_state           <= 0;
                    end
                end
            endcase
        end
    end

    function automatic int low_idx(input logic [N-1:0] busy);
        for (int i = 0; i < N; i++) if (!busy[i]) return i;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_winner(input logic [N-1:0] stb, input int rr);
        for (int k = 0; k < N; k++) if (stb[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n               = 1'b0;
        bus.req_STB         = '0;
        bus.req_a           = '0;
        bus.req_b           = '0;
        bus.rsp_module_BUSY = '0;
        dv_rand             = 1'b0;
        dv_lat              = 2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n               = 1'b0;
        bus.req_STB         = '0;
        bus.req_a           = '0;
        bus.req_b           = '0;
        bus.rsp_module_BUSY = '0;
        @(negedge clk);
        n_total++;
        if (bus.req_BUSY !== 4'hF || bus.rsp_STB !== 4'h0 || bus.div_input_STB !== 1'b0 ||
            bus.output_module_BUSY !== 1'b1)
            $display("FAIL reset_handshake: busy=%h rsp_stb=%h div_stb=%b omb=%b required F/0/0/1",
                     bus.req_BUSY, bus.rsp_STB, bus.div_input_STB, bus.output_module_BUSY);
        else n_pass++;
        n_total++;
        if (bus.grant_idx !== 2'd0 || bus.arb_active !== 1'b0 || bus.rsp_div !== 32'h0 ||
            bus.div_input_a !== 32'h0 || bus.div_input_b !== 32'h0)
            $display("FAIL reset_data: grant=%0d active=%b rsp=%h a=%h b=%h required all zero",
                     bus.grant_idx, bus.arb_active, bus.rsp_div, bus.div_input_a, bus.div_input_b);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus.arb_active !== 1'b0 || bus.req_BUSY !== 4'hF)
            $display("FAIL idle_no_req: active=%b busy=%h required 0/F", bus.arb_active, bus.req_BUSY);
        else n_pass++;
    endtask

    task automatic test_single();
        int lows = 0;
        do_reset();
        dv_lat = 3;
        bus.req_a[31:0] = 32'h40C00000;
        bus.req_b[31:0] = 32'h40000000;
        bus.req_STB     = 4'b0001;
        @(negedge clk);
        n_total++;
        if (bus.req_BUSY !== 4'b1110)
            $display("FAIL single_grant_latency: busy=%b required 1110", bus.req_BUSY);
        else n_pass++;
        lows = 1;
        @(negedge clk);
        bus.req_STB = '0;
        n_total++;
        if (bus.div_input_STB !== 1'b1 || bus.req_BUSY !== 4'hF ||
            bus.div_input_a !== 32'h40C00000 || bus.div_input_b !== 32'h40000000)
            $display("FAIL single_issue: stb=%b busy=%h a=%h b=%h required 1/F/40c00000/40000000",
                     bus.div_input_STB, bus.req_BUSY, bus.div_input_a, bus.div_input_b);
        else n_pass++;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_BUSY !== 4'hF) lows++;
            if (bus.rsp_STB !== 4'h0) break;
        end
        n_total++;
        if (bus.rsp_STB !== 4'b0001 || bus.rsp_div !== 32'h40400000 || bus.grant_idx !== 2'd0)
            $display("FAIL single_result: rsp_stb=%b rsp=%h grant=%0d required 0001/40400000/0",
                     bus.rsp_STB, bus.rsp_div, bus.grant_idx);
        else n_pass++;
        n_total++;
        if (lows != 1)
            $display("FAIL single_busy_window: low cycles=%0d required 1", lows);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.rsp_STB !== 4'h0 || bus.arb_active !== 1'b0)
            $display("FAIL single_return_idle: rsp_stb=%b active=%b required 0/0", bus.rsp_STB, bus.arb_active);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int k = 0;
        int got;
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = 32'h3F800000;
            bus.req_b[32*i +: 32] = 32'h40000000;
        end
        bus.req_STB = 4'hF;
        for (int c = 0; c < 400 && k < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_STB !== 4'h0) begin
                got = oh_idx(bus.rsp_STB);
                n_total++;
                if (got != exp_order[k] || bus.rsp_div !== 32'h3F000000)
                    $display("FAIL rr_order_%0d: served=%0d rsp=%h required %0d/3f000000",
                             k, got, bus.rsp_div, exp_order[k]);
                else n_pass++;
                k++;
            end
        end
        n_total++;
        if (k != 5) $display("FAIL rr_count: served=%0d required 5", k);
        else n_pass++;
        bus.req_STB = '0;
    endtask

    task automatic test_rsp_backpressure();
        int bad = 0;
        do_reset();
        bus.rsp_module_BUSY    = 4'b0100;
        bus.req_a[64 +: 32]    = 32'h3F800000;
        bus.req_b[64 +: 32]    = 32'h00000000;
        bus.req_STB            = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.div_input_STB) bus.req_STB[2] = 1'b0;
            if (bus.rsp_STB !== 4'h0) break;
        end
        bus.req_STB[2]      = 1'b0;
        bus.req_a[0 +: 32]  = 32'h3F800000;
        bus.req_b[0 +: 32]  = 32'h40000000;
        bus.req_a[96 +: 32] = 32'h3F800000;
        bus.req_b[96 +: 32] = 32'h40000000;
        bus.req_STB         = 4'b1001;
        for (int c = 0; c < 20; c++) begin
            n_total++;
            if (bus.rsp_STB !== 4'b0100 || bus.rsp_div !== 32'h7F800000 ||
                bus.arb_active !== 1'b1 || bus.req_BUSY !== 4'hF) begin
                $display("FAIL hold_cycle_%0d: rsp_stb=%b rsp=%h active=%b busy=%h required 0100/7f800000/1/F",
                         c, bus.rsp_STB, bus.rsp_div, bus.arb_active, bus.req_BUSY);
                bad++;
            end else n_pass++;
            @(negedge clk);
        end
        bus.rsp_module_BUSY = '0;
        @(negedge clk);
        n_total++;
        if (bus.rsp_STB !== 4'h0 || bus.arb_active !== 1'b0)
            $display("FAIL hold_release: rsp_stb=%b active=%b required 0/0", bus.rsp_STB, bus.arb_active);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.req_BUSY !== 4'b0111 || bus.grant_idx !== 2'd3)
            $display("FAIL hold_next_scan: busy=%b grant=%0d required 0111/3", bus.req_BUSY, bus.grant_idx);
        else n_pass++;
        bus.req_STB = '0;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        bus.req_a[32 +: 32] = 32'h40C00000;
        bus.req_b[32 +: 32] = 32'h40000000;
        bus.req_STB         = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.div_input_STB) bus.req_STB = '0;
            if (bus.rsp_STB !== 4'h0) break;
        end
        @(negedge clk);
        dv_lat              = 10;
        bus.req_a[64 +: 32] = 32'h40C00000;
        bus.req_b[64 +: 32] = 32'h40000000;
        bus.req_STB         = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.div_input_STB) bus.req_STB = '0;
            if (bus.output_module_BUSY === 1'b0) break;
        end
        n_total++;
        if (bus.output_module_BUSY !== 1'b0)
            $display("FAIL midrst_reach_wait: omb=%b required 0", bus.output_module_BUSY);
        else n_pass++;
        bus.req_STB = '0;
        rst_n       = 1'b0;
        #1;
        n_total++;
        if (bus.req_BUSY !== 4'hF || bus.rsp_STB !== 4'h0 || bus.div_input_STB !== 1'b0 ||
            bus.output_module_BUSY !== 1'b1 || bus.arb_active !== 1'b0)
            $display("FAIL midrst_async: busy=%h rsp_stb=%h div_stb=%b omb=%b active=%b required F/0/0/1/0",
                     bus.req_BUSY, bus.rsp_STB, bus.div_input_STB, bus.output_module_BUSY, bus.arb_active);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        dv_lat = 2;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rsp_STB !== 4'h0) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL midrst_no_result: rsp cycles=%0d required 0", seen);
        else n_pass++;
        bus.req_STB = 4'hF;
        @(negedge clk);
        n_total++;
        if (bus.req_BUSY !== 4'b1110 || bus.grant_idx !== 2'd0)
            $display("FAIL midrst_rr_restart: busy=%b grant=%0d required 1110/0", bus.req_BUSY, bus.grant_idx);
        else n_pass++;
        bus.req_STB = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        bus.req_a[32 +: 32] = 32'h40C00000;
        bus.req_b[32 +: 32] = 32'h40000000;
        bus.req_STB         = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_BUSY[1] === 1'b0) break;
        end
        n_total++;
        if (bus.req_BUSY !== 4'b1101)
            $display("FAIL wd_grant: busy=%b required 1101", bus.req_BUSY);
        else n_pass++;
        bus.req_a[0 +: 32]  = 32'h40C00000;
        bus.req_b[0 +: 32]  = 32'h40000000;
        bus.req_a[96 +: 32] = 32'h3F800000;
        bus.req_b[96 +: 32] = 32'h40000000;
        bus.req_STB         = 4'b1001;
        @(negedge clk);
        n_total++;
        if (bus.div_input_STB !== 1'b0 || bus.arb_active !== 1'b0 || bus.req_BUSY !== 4'hF)
            $display("FAIL wd_back_to_idle: div_stb=%b active=%b busy=%h required 0/0/F",
                     bus.div_input_STB, bus.arb_active, bus.req_BUSY);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.req_BUSY !== 4'b1110 || bus.grant_idx !== 2'd0)
            $display("FAIL wd_rr_kept: busy=%b grant=%0d required 1110/0", bus.req_BUSY, bus.grant_idx);
        else n_pass++;
        @(negedge clk);
        bus.req_STB = '0;
        n_total++;
        if (bus.div_input_STB !== 1'b1 || bus.div_input_a !== 32'h40C00000)
            $display("FAIL wd_issue_req0: div_stb=%b a=%h required 1/40c00000", bus.div_input_STB, bus.div_input_a);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0]  exp_q [N][$];
        logic [N-1:0] stb_prev = '0;
        logic [N-1:0] acc      = '0;
        logic [N-1:0] acc_prev = '0;
        logic [N-1:0] rsp_hs;
        int accepted = 0, returned = 0, rr_model = 0, cyc = 0;
        int exp_w, got_w, left;
        logic [31:0] exp_d;
        do_reset();
        dv_rand = 1'b1;
        while (cyc < 40000 && (accepted < NUM_OPS || returned < accepted || bus.req_STB != '0)) begin
            @(negedge clk);
            cyc++;
            n_total++;
            if ($countones(~bus.req_BUSY) > 1 || !$onehot0(bus.rsp_STB) ||
                (bus.output_module_BUSY === 1'b0 &&
                 (bus.arb_active !== 1'b1 || bus.rsp_STB !== '0 || bus.req_BUSY !== 4'hF)))
                $display("FAIL rnd_invariant_cyc%0d: busy=%b rsp_stb=%b omb=%b active=%b",
                         cyc, bus.req_BUSY, bus.rsp_STB, bus.output_module_BUSY, bus.arb_active);
            else n_pass++;
            got_w = low_idx(bus.req_BUSY);
            if (got_w >= 0) begin
                exp_w = rr_winner(stb_prev, rr_model);
                n_total++;
                if (got_w != exp_w)
                    $display("FAIL rnd_grant_cyc%0d: granted=%0d required %0d (stb=%b rr=%0d)",
                             cyc, got_w, exp_w, stb_prev, rr_model);
                else n_pass++;
            end
            for (int i = 0; i < N; i++) begin
                if (acc_prev[i] || !bus.req_STB[i]) begin
                    bus.req_STB[i] = (accepted < NUM_OPS) && ($urandom_range(0, 3) == 0);
                    bus.req_a[32*i +: 32] = $urandom;
                    bus.req_b[32*i +: 32] = $urandom;
                end
            end
            bus.rsp_module_BUSY = N'($urandom) & N'($urandom);
            acc    = bus.req_STB & ~bus.req_BUSY;
            rsp_hs = bus.rsp_STB & ~bus.rsp_module_BUSY;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    exp_q[i].push_back(mock_quotient(bus.req_a[32*i +: 32], bus.req_b[32*i +: 32]));
                    accepted++;
                end
                if (rsp_hs[i]) begin
                    n_total++;
                    if (exp_q[i].size() == 0) begin
                        $display("FAIL rnd_unexpected_rsp: requester=%0d rsp=%h required no result", i, bus.rsp_div);
                    end else begin
                        exp_d = exp_q[i].pop_front();
                        if (bus.rsp_div !== exp_d)
                            $display("FAIL rnd_rsp_data: requester=%0d rsp=%h required %h", i, bus.rsp_div, exp_d);
                        else n_pass++;
                    end
                    returned++;
                    rr_model = (i + 1) % N;
                end
            end
            acc_prev = acc;
            stb_prev = bus.req_STB;
        end
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        n_total++;
        if (accepted < NUM_OPS || returned != accepted || left != 0)
            $display("FAIL rnd_totals: accepted=%0d returned=%0d outstanding=%0d required >=%0d/equal/0",
                     accepted, returned, left, NUM_OPS);
        else n_pass++;
        dv_rand = 1'b0;
        bus.rsp_module_BUSY = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rsp_backpressure();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
